// File: rtl/sdram_burst_arbiter.sv
// Two-port burst-read arbiter in front of io_sdram: video (V) has priority, the CPU/DMA port (C)
// is protected by a streak limit, and a watchdog closes bursts whose done never arrives.
`timescale 1ns/1ps
module sdram_burst_arbiter #(
  parameter int MAX_V_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W           = 13
) (
  input  logic        clk_sdram,
  input  logic        reset,
  input  logic        v_burst_rd,
  input  logic [24:0] v_burst_addr,
  input  logic [10:0] v_burst_len,
  input  logic        v_burst_32bit,
  output logic        v_burst_data_valid,
  output logic        v_burst_data_done,
  input  logic        c_burst_rd,
  input  logic [24:0] c_burst_addr,
  input  logic [10:0] c_burst_len,
  input  logic        c_burst_32bit,
  output logic        c_burst_data_valid,
  output logic        c_burst_data_done,
  output logic [31:0] up_burst_data,
  output logic        dn_burst_rd,
  output logic [24:0] dn_burst_addr,
  output logic [10:0] dn_burst_len,
  output logic        dn_burst_32bit,
  input  logic [31:0] dn_burst_data,
  input  logic        dn_burst_data_valid,
  input  logic        dn_burst_data_done,
  output logic        busy,
  output logic        owner,
  output logic        timeout_err,
  output logic        overflow_err,
  input  logic        clear_err
);

  localparam int STREAK_W = $clog2(MAX_V_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_V_STREAK);
  localparam logic [TO_W-1:0]     WD_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic                r_pend_v;
  logic                r_pend_c;
  logic [24:0]         r_v_addr;
  logic [10:0]         r_v_len;
  logic                r_v_32bit;
  logic [24:0]         r_c_addr;
  logic [10:0]         r_c_len;
  logic                r_c_32bit;
  logic [STREAK_W-1:0] r_streak;
  logic [TO_W-1:0]     r_wd;
  logic                r_owner;
  logic                r_dn_rd;
  logic [24:0]         r_dn_addr;
  logic [10:0]         r_dn_len;
  logic                r_dn_32bit;
  logic                r_timeout_err;
  logic                r_overflow_err;

  logic        w_v_elig;
  logic        w_c_elig;
  logic        w_grant;
  logic        w_grant_c;
  logic        w_wd_hit;
  logic        w_fin;
  logic        w_overflow;
  logic [24:0] w_sel_addr;
  logic [10:0] w_sel_len;
  logic        w_sel_32bit;

  // A same-cycle pulse is eligible; its fields bypass the latch and come from the inputs.
  assign w_v_elig   = r_pend_v | v_burst_rd;
  assign w_c_elig   = r_pend_c | c_burst_rd;
  assign w_overflow = (v_burst_rd & r_pend_v) | (c_burst_rd & r_pend_c);

  assign w_sel_addr  = w_grant_c ? (r_pend_c ? r_c_addr  : c_burst_addr)
                                 : (r_pend_v ? r_v_addr  : v_burst_addr);
  assign w_sel_len   = w_grant_c ? (r_pend_c ? r_c_len   : c_burst_len)
                                 : (r_pend_v ? r_v_len   : v_burst_len);
  assign w_sel_32bit = w_grant_c ? (r_pend_c ? r_c_32bit : c_burst_32bit)
                                 : (r_pend_v ? r_v_32bit : v_burst_32bit);

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_c    = 1'b0;
    w_wd_hit     = 1'b0;
    w_fin        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_v_elig | w_c_elig) begin
          w_grant      = 1'b1;
          w_grant_c    = w_c_elig & (~w_v_elig | (r_streak == STREAK_MAX));
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        // A real done in the deadline cycle takes precedence over the synthetic one.
        w_wd_hit = ~dn_burst_data_done & (r_wd == WD_LAST);
        w_fin    = dn_burst_data_done | w_wd_hit;
        if (w_fin) w_state_next = S_HOLD;
      end
      S_HOLD:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sdram) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pend_v       <= 1'b0;
      r_pend_c       <= 1'b0;
      r_v_addr       <= '0;
      r_v_len        <= '0;
      r_v_32bit      <= 1'b0;
      r_c_addr       <= '0;
      r_c_len        <= '0;
      r_c_32bit      <= 1'b0;
      r_streak       <= '0;
      r_wd           <= '0;
      r_owner        <= 1'b0;
      r_dn_rd        <= 1'b0;
      r_dn_addr      <= '0;
      r_dn_len       <= '0;
      r_dn_32bit     <= 1'b0;
      r_timeout_err  <= 1'b0;
      r_overflow_err <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_dn_rd        <= w_grant;
      r_timeout_err  <= w_wd_hit | (r_timeout_err & ~clear_err);
      r_overflow_err <= w_overflow | (r_overflow_err & ~clear_err);

      // First request wins: a pulse while pending leaves the latched fields untouched.
      if (v_burst_rd & ~r_pend_v) begin
        r_v_addr  <= v_burst_addr;
        r_v_len   <= v_burst_len;
        r_v_32bit <= v_burst_32bit;
      end
      if (c_burst_rd & ~r_pend_c) begin
        r_c_addr  <= c_burst_addr;
        r_c_len   <= c_burst_len;
        r_c_32bit <= c_burst_32bit;
      end
      r_pend_v <= (w_grant & ~w_grant_c) ? 1'b0 : (r_pend_v | v_burst_rd);
      r_pend_c <= (w_grant &  w_grant_c) ? 1'b0 : (r_pend_c | c_burst_rd);

      if (w_grant) begin
        r_owner    <= w_grant_c;
        r_dn_addr  <= w_sel_addr;
        r_dn_len   <= w_sel_len;
        r_dn_32bit <= w_sel_32bit;
        r_wd       <= '0;
        if (~w_grant_c & w_c_elig)
          r_streak <= (r_streak == STREAK_MAX) ? r_streak : r_streak + 1'b1;
        else
          r_streak <= '0;
      end else if (r_state == S_ACTIVE) begin
        r_wd <= r_wd + 1'b1;
      end
    end
  end

  assign v_burst_data_valid = (r_state == S_ACTIVE) & ~r_owner & dn_burst_data_valid;
  assign c_burst_data_valid = (r_state == S_ACTIVE) &  r_owner & dn_burst_data_valid;
  assign v_burst_data_done  = w_fin & ~r_owner;
  assign c_burst_data_done  = w_fin &  r_owner;

  assign up_burst_data  = dn_burst_data;
  assign dn_burst_rd    = r_dn_rd;
  assign dn_burst_addr  = r_dn_addr;
  assign dn_burst_len   = r_dn_len;
  assign dn_burst_32bit = r_dn_32bit;
  assign busy           = (r_state != S_IDLE);
  assign owner          = r_owner;
  assign timeout_err    = r_timeout_err;
  assign overflow_err   = r_overflow_err;

endmodule
